// File: rtl/sauria_obi2axi_bridge.sv
// OBI data port to single-beat AXI4 manager with up to MAX_OUTST transactions in flight.
// A small type-order FIFO steers R/B back-pressure so OBI responses return in request order.
module sauria_obi2axi_bridge #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 3,
  parameter int unsigned AXI_ID     = 0,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic                    idle_o,
  output logic                    aw_valid_o,
  input  logic                    aw_ready_i,
  output logic [ADDR_WIDTH-1:0]   aw_addr_o,
  output logic [ID_WIDTH-1:0]     aw_id_o,
  output logic [7:0]              aw_len_o,
  output logic [2:0]              aw_size_o,
  output logic [1:0]              aw_burst_o,
  output logic                    aw_lock_o,
  output logic [3:0]              aw_cache_o,
  output logic [2:0]              aw_prot_o,
  output logic [3:0]              aw_qos_o,
  output logic [3:0]              aw_region_o,
  output logic [USER_WIDTH-1:0]   aw_user_o,
  output logic                    w_valid_o,
  input  logic                    w_ready_i,
  output logic [DATA_WIDTH-1:0]   w_data_o,
  output logic [DATA_WIDTH/8-1:0] w_strb_o,
  output logic                    w_last_o,
  input  logic                    b_valid_i,
  output logic                    b_ready_o,
  input  logic [1:0]              b_resp_i,
  input  logic [ID_WIDTH-1:0]     b_id_i,
  output logic                    ar_valid_o,
  input  logic                    ar_ready_i,
  output logic [ADDR_WIDTH-1:0]   ar_addr_o,
  output logic [ID_WIDTH-1:0]     ar_id_o,
  output logic [7:0]              ar_len_o,
  output logic [2:0]              ar_size_o,
  output logic [1:0]              ar_burst_o,
  output logic                    ar_lock_o,
  output logic [3:0]              ar_cache_o,
  output logic [2:0]              ar_prot_o,
  output logic [3:0]              ar_qos_o,
  output logic [3:0]              ar_region_o,
  output logic [USER_WIDTH-1:0]   ar_user_o,
  input  logic                    r_valid_i,
  output logic                    r_ready_o,
  input  logic [DATA_WIDTH-1:0]   r_data_i,
  input  logic [1:0]              r_resp_i,
  input  logic                    r_last_i,
  input  logic [ID_WIDTH-1:0]     r_id_i
);

  localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [2:0]  SIZE  = 3'($clog2(DATA_WIDTH / 8));

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(MAX_OUTST - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  logic                  aw_done_r, w_done_r;
  logic [MAX_OUTST-1:0]  order_r;
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      cnt_r;
  logic                  rvalid_r, err_r;
  logic [DATA_WIDTH-1:0] rdata_r;

  logic full_s, empty_s, head_we_s;
  logic aw_hs_s, w_hs_s, r_hs_s, b_hs_s, pop_s, wr_gnt_s, rd_gnt_s, gnt_s;
  logic unused_s;

  assign unused_s  = ^{b_id_i, r_id_i, r_last_i};

  // full uses the registered count only, so a pop never frees a slot in the same cycle
  assign full_s    = (cnt_r == CNT_W'(MAX_OUTST));
  assign empty_s   = (cnt_r == {CNT_W{1'b0}});
  assign head_we_s = order_r[rd_ptr_r];

  assign ar_valid_o = req_i & ~we_i & ~full_s;
  assign aw_valid_o = req_i &  we_i & ~full_s & ~aw_done_r;
  assign w_valid_o  = req_i &  we_i & ~full_s & ~w_done_r;

  assign aw_hs_s  = aw_valid_o & aw_ready_i;
  assign w_hs_s   = w_valid_o & w_ready_i;
  assign wr_gnt_s = req_i & we_i & ~full_s & (aw_done_r | aw_hs_s) & (w_done_r | w_hs_s);
  assign rd_gnt_s = ar_valid_o & ar_ready_i;
  assign gnt_s    = wr_gnt_s | rd_gnt_s;
  assign gnt_o    = gnt_s;

  assign r_ready_o = ~empty_s & ~head_we_s;
  assign b_ready_o = ~empty_s &  head_we_s;
  assign r_hs_s    = r_valid_i & r_ready_o;
  assign b_hs_s    = b_valid_i & b_ready_o;
  assign pop_s     = r_hs_s | b_hs_s;

  assign idle_o = empty_s & ~aw_done_r & ~w_done_r;

  assign aw_addr_o   = addr_i;
  assign ar_addr_o   = addr_i;
  assign aw_id_o     = ID_WIDTH'(AXI_ID);
  assign ar_id_o     = ID_WIDTH'(AXI_ID);
  assign aw_len_o    = 8'd0;
  assign ar_len_o    = 8'd0;
  assign aw_size_o   = SIZE;
  assign ar_size_o   = SIZE;
  assign aw_burst_o  = 2'b01;
  assign ar_burst_o  = 2'b01;
  assign aw_lock_o   = 1'b0;
  assign ar_lock_o   = 1'b0;
  assign aw_cache_o  = 4'b0010;
  assign ar_cache_o  = 4'b0010;
  assign aw_prot_o   = 3'b000;
  assign ar_prot_o   = 3'b000;
  assign aw_qos_o    = 4'b0000;
  assign ar_qos_o    = 4'b0000;
  assign aw_region_o = 4'b0000;
  assign ar_region_o = 4'b0000;
  assign aw_user_o   = {USER_WIDTH{1'b0}};
  assign ar_user_o   = {USER_WIDTH{1'b0}};
  assign w_data_o    = wdata_i;
  assign w_strb_o    = be_i;
  assign w_last_o    = 1'b1;

  assign rvalid_o = rvalid_r;
  assign rdata_o  = rdata_r;
  assign err_o    = err_r;

  // Sticky AW/W completion flags; the grant closes the write and clears both
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else if (gnt_s) begin
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      aw_done_r <= aw_done_r | aw_hs_s;
      w_done_r  <= w_done_r | w_hs_s;
    end
  end

  // Order FIFO of transaction types plus the outstanding count
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      order_r  <= {MAX_OUTST{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      if (gnt_s) begin
        order_r[wr_ptr_r] <= we_i;
        wr_ptr_r          <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({gnt_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_W'(1);
        2'b01:   cnt_r <= cnt_r - CNT_W'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Registered OBI response; data and error hold between responses
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_r <= 1'b0;
      rdata_r  <= {DATA_WIDTH{1'b0}};
      err_r    <= 1'b0;
    end else begin
      rvalid_r <= pop_s;
      if (r_hs_s) begin
        rdata_r <= r_data_i;
        err_r   <= (r_resp_i != 2'b00);
      end else if (b_hs_s) begin
        rdata_r <= {DATA_WIDTH{1'b0}};
        err_r   <= (b_resp_i != 2'b00);
      end else begin
        rdata_r <= rdata_r;
        err_r   <= err_r;
      end
    end
  end

endmodule

// File: tb/tb_sauria_obi2axi_bridge.sv
// Bench for sauria_obi2axi_bridge: directed OBI/AXI stimulus, expected responses
// queued at request time and compared in order whenever rvalid_o fires.
module tb_sauria_obi2axi_bridge;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req, gnt, we, rvalid, err, idle;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] be;
  logic aw_valid, aw_ready, w_valid, w_ready, w_last;
  logic b_valid, b_ready, ar_valid, ar_ready, r_valid, r_ready, r_last;
  logic [31:0] aw_addr, ar_addr, w_data, r_data;
  logic [3:0] w_strb;
  logic [2:0] aw_id, ar_id, b_id, r_id;
  logic [7:0] aw_len, ar_len;
  logic [2:0] aw_size, ar_size, aw_prot, ar_prot;
  logic [1:0] aw_burst, ar_burst, b_resp, r_resp;
  logic aw_lock, ar_lock;
  logic [3:0] aw_cache, ar_cache, aw_qos, ar_qos, aw_region, ar_region;
  logic [0:0] aw_user, ar_user;

  int checks = 0;
  int failures = 0;
  rsp_t sb_q[$];
  rsp_t mon_exp;

  always #5 clk = ~clk;

  sauria_obi2axi_bridge dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
    .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .idle_o(idle),
    .aw_valid_o(aw_valid), .aw_ready_i(aw_ready), .aw_addr_o(aw_addr), .aw_id_o(aw_id),
    .aw_len_o(aw_len), .aw_size_o(aw_size), .aw_burst_o(aw_burst), .aw_lock_o(aw_lock),
    .aw_cache_o(aw_cache), .aw_prot_o(aw_prot), .aw_qos_o(aw_qos), .aw_region_o(aw_region),
    .aw_user_o(aw_user),
    .w_valid_o(w_valid), .w_ready_i(w_ready), .w_data_o(w_data), .w_strb_o(w_strb),
    .w_last_o(w_last),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_resp_i(b_resp), .b_id_i(b_id),
    .ar_valid_o(ar_valid), .ar_ready_i(ar_ready), .ar_addr_o(ar_addr), .ar_id_o(ar_id),
    .ar_len_o(ar_len), .ar_size_o(ar_size), .ar_burst_o(ar_burst), .ar_lock_o(ar_lock),
    .ar_cache_o(ar_cache), .ar_prot_o(ar_prot), .ar_qos_o(ar_qos), .ar_region_o(ar_region),
    .ar_user_o(ar_user),
    .r_valid_i(r_valid), .r_ready_o(r_ready), .r_data_i(r_data), .r_resp_i(r_resp),
    .r_last_i(r_last), .r_id_i(r_id)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    rsp_t r;
    r.data = d;
    r.err  = e;
    sb_q.push_back(r);
  endtask

  // In-order response scoreboard
  always @(negedge clk) begin
    if (rst_n && rvalid) begin
      if (sb_q.size() == 0) begin
        check("rvalid_unexpected", 64'd1, 64'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        check("rsp_rdata", rdata, mon_exp.data);
        check("rsp_err", err, mon_exp.err);
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; be = 4'd0; wdata = 32'd0;
    aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    b_valid = 1'b0; b_resp = 2'b00; b_id = 3'd0;
    r_valid = 1'b0; r_data = 32'd0; r_resp = 2'b00; r_last = 1'b1; r_id = 3'd0;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    check("rst_rvalid", rvalid, 1'b0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", err, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_ar_valid", ar_valid, 1'b0);

    // 1: single read, zero-latency grant
    tick(); req = 1'b1; we = 1'b0; addr = 32'h100; ar_ready = 1'b1;
    #1;
    check("t1_gnt", gnt, 1'b1);
    check("t1_ar_addr", ar_addr, 32'h100);
    check("t1_ar_size", ar_size, 3'd2);
    check("t1_ar_cache", ar_cache, 4'b0010);
    check("t1_ar_burst", ar_burst, 2'b01);
    push(32'hCAFE0001, 1'b0);
    tick(); req = 1'b0; ar_ready = 1'b0; r_valid = 1'b1; r_data = 32'hCAFE0001;
    #1;
    check("t1_r_ready", r_ready, 1'b1);
    check("t1_rvalid_pre", rvalid, 1'b0);
    tick(); r_valid = 1'b0;
    #1;
    check("t1_rvalid", rvalid, 1'b1);
    tick();
    #1;
    check("t1_rvalid_one", rvalid, 1'b0);
    check("t1_rdata_hold", rdata, 32'hCAFE0001);

    // 2: write with AW and W accepted in different cycles
    tick(); req = 1'b1; we = 1'b1; addr = 32'h200; be = 4'b0011; wdata = 32'h12345678;
    #1;
    check("t2_aw_valid", aw_valid, 1'b1);
    check("t2_w_strb", w_strb, 4'b0011);
    check("t2_w_last", w_last, 1'b1);
    check("t2_gnt_c1", gnt, 1'b0);
    tick(); aw_ready = 1'b1;
    #1;
    check("t2_gnt_c2", gnt, 1'b0);
    for (int c = 3; c <= 4; c++) begin
      tick(); aw_ready = 1'b0;
      #1;
      check("t2_aw_drop", aw_valid, 1'b0);
      check("t2_w_valid", w_valid, 1'b1);
      check("t2_gnt_wait", gnt, 1'b0);
    end
    tick(); w_ready = 1'b1;
    #1;
    check("t2_gnt_c5", gnt, 1'b1);
    push(32'd0, 1'b0);
    tick(); req = 1'b0; w_ready = 1'b0; b_valid = 1'b1; b_resp = 2'b00;
    #1;
    check("t2_b_ready", b_ready, 1'b1);
    tick(); b_valid = 1'b0;
    tick();
    #1;
    check("t2_idle", idle, 1'b1);

    // 3: five reads against four slots, R withheld
    for (int i = 0; i < 4; i++) begin
      tick(); req = 1'b1; we = 1'b0; addr = 32'h300 + 32'(4 * i); ar_ready = 1'b1;
      #1;
      check("t3_gnt", gnt, 1'b1);
      push(32'hA0000000 + 32'(i), 1'b0);
    end
    tick(); addr = 32'h310;
    #1;
    check("t3_full_ar_valid", ar_valid, 1'b0);
    check("t3_full_gnt", gnt, 1'b0);
    tick(); r_valid = 1'b1; r_data = 32'hA0000000;
    #1;
    check("t3_pop_r_ready", r_ready, 1'b1);
    check("t3_no_bypass", gnt, 1'b0);
    tick(); r_valid = 1'b0;
    #1;
    check("t3_gnt5", gnt, 1'b1);
    push(32'hA0000004, 1'b0);
    tick(); req = 1'b0; ar_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      r_valid = 1'b1; r_data = 32'hA0000000 + 32'(i);
      #1;
      check("t3_drain_r_ready", r_ready, 1'b1);
      tick();
    end
    r_valid = 1'b0;
    tick();
    #1;
    check("t3_idle", idle, 1'b1);

    // 4: W,R,W issued; slave offers R before the first B
    aw_ready = 1'b1; w_ready = 1'b1; ar_ready = 1'b1;
    tick(); req = 1'b1; we = 1'b1; addr = 32'h400;
    #1; check("t4_gnt_w0", gnt, 1'b1); push(32'd0, 1'b0);
    tick(); we = 1'b0; addr = 32'h404;
    #1; check("t4_gnt_r", gnt, 1'b1); push(32'hBEEF0004, 1'b0);
    tick(); we = 1'b1; addr = 32'h408;
    #1; check("t4_gnt_w1", gnt, 1'b1); push(32'd0, 1'b1);
    tick(); req = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; ar_ready = 1'b0;
    r_valid = 1'b1; r_data = 32'hBEEF0004;
    #1; check("t4_r_blocked", r_ready, 1'b0);
    tick();
    #1; check("t4_r_blocked2", r_ready, 1'b0);
    b_valid = 1'b1; b_resp = 2'b00;
    #1; check("t4_b_ready", b_ready, 1'b1);
    tick(); b_valid = 1'b0;
    #1; check("t4_r_ready", r_ready, 1'b1);
    check("t4_b_blocked", b_ready, 1'b0);
    tick(); r_valid = 1'b0; b_valid = 1'b1; b_resp = 2'b10;
    #1; check("t4_b_ready2", b_ready, 1'b1);
    tick(); b_valid = 1'b0; b_resp = 2'b00;
    tick();

    // 5: SLVERR read then OKAY read
    ar_ready = 1'b1;
    tick(); req = 1'b1; we = 1'b0; addr = 32'h500;
    #1; check("t5_gnt0", gnt, 1'b1); push(32'hDEAD0000, 1'b1);
    tick(); addr = 32'h504;
    #1; check("t5_gnt1", gnt, 1'b1); push(32'h00001111, 1'b0);
    tick(); req = 1'b0; ar_ready = 1'b0;
    r_valid = 1'b1; r_data = 32'hDEAD0000; r_resp = 2'b10;
    tick(); r_data = 32'h00001111; r_resp = 2'b00;
    tick(); r_valid = 1'b0;
    tick();
    #1; check("t5_idle", idle, 1'b1);

    // 6: reset with three reads outstanding and an R beat on the wire
    ar_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); req = 1'b1; we = 1'b0; addr = 32'h600 + 32'(4 * i);
      #1; check("t6_gnt", gnt, 1'b1);
    end
    tick(); req = 1'b0; ar_ready = 1'b0; rst_n = 1'b0; r_valid = 1'b1; r_data = 32'h77;
    #1; check("t6_busy", idle, 1'b0);
    tick(); rst_n = 1'b1; r_valid = 1'b0;
    #1;
    check("t6_rvalid", rvalid, 1'b0);
    check("t6_rdata", rdata, 32'd0);
    check("t6_idle", idle, 1'b1);
    check("t6_ar_valid", ar_valid, 1'b0);
    check("t6_aw_valid", aw_valid, 1'b0);
    check("t6_w_valid", w_valid, 1'b0);
    check("t6_r_ready", r_ready, 1'b0);
    tick(); req = 1'b1; we = 1'b0; addr = 32'h700; ar_ready = 1'b1;
    #1; check("t6_gnt_after", gnt, 1'b1); push(32'h600D0000, 1'b0);
    tick(); req = 1'b0; ar_ready = 1'b0; r_valid = 1'b1; r_data = 32'h600D0000;
    tick(); r_valid = 1'b0;
    tick(); tick();
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("final_idle", idle, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
